rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Two-requester arbiter in front of a synchronous ROM with a one-cycle
// registered read. Each granted read runs through four states
// (IDLE -> ADDR -> DATA -> RESP), so one transaction takes four cycles.
// A request sampled in IDLE is acknowledged three cycles later.
// Every output comes straight from a register.
//
// Optional feature (macro ROM_ARB_RR_EN):
//   defined   : simultaneous requests are resolved round-robin. The grant
//               goes to the requester that did not win last time
//               (last_grant_q is reset to 1, so requester 0 wins first).
//   undefined : fixed priority. Requester 0 always wins, and requester 1
//               can starve while req0 is held.
//
// Ports
//   clk       in   clock; all logic runs on its rising edge
//   rst       in   synchronous active-high reset
//   req0/req1 in   level read requests, held until the matching ack
//   addr0/1   in   requester addresses (A_WIDTH), stable while req is high
//   ack0/ack1 out  one-cycle pulse; rdata is valid for that requester
//   rdata     out  shared read data (D_WIDTH), held between acks
//   busy      out  high in every state except IDLE
//   rom_addr  out  address to the ROM (A_WIDTH)
//   rom_data  in   registered ROM output (D_WIDTH)
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic               req1,
    input  logic [A_WIDTH-1:0] addr1,
    output logic               ack0,
    output logic               ack1,
    output logic [D_WIDTH-1:0] rdata,
    output logic               busy,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [D_WIDTH-1:0] rom_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic [A_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]         ack_q, ack_d;
    logic               busy_q, busy_d;

    logic               any_req;
    logic               winner;

    assign any_req = req0 | req1;

`ifdef ROM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // With both requesting, the grant goes to whoever did not win last time.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    always_comb begin
        winner = ~req0;
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
`ifdef ROM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Requests and addresses are used only here. After the grant
                // the transaction depends only on owner_q and rom_addr_q.
                if (any_req) begin
                    owner_d    = winner;
                    rom_addr_d = winner ? addr1 : addr0;
`ifdef ROM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // The ROM samples rom_addr_q on the edge that closes this state.
                state_d = ST_DATA;
            end
            ST_DATA: begin
                rdata_d = rom_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // The ack is raised for the cycle after DATA, which is RESP. It goes
    // only to the owner latched at grant time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_d[gi] = (state_q == ST_DATA) && (owner_q == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
`ifdef ROM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
`ifdef ROM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign rom_addr = rom_addr_q;

endmodule
